// File: rtl/banda_sched.sv
// banda_sched -- round-robin scheduler sharing one 3-bit part-code register
// between four assembly-line stations.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   per-station request (bit i = station i)
//   code[11:0] per-station part code, station i at code[3i+2:3i]
//   take       downstream consumed the held code (only looked at in HOLD)
//   reg_load   load strobe to the shared stage register
//   reg_clear  clear strobe to the shared stage register
//   reg_a/b/c  winner code bits {a,b,c} = {code[3i+2], code[3i+1], code[3i]}
//   gnt[3:0]   one-hot grant, high for the LOAD cycle
//   owner[1:0] station whose code sits in the register
//   valid      shared register holds a live code (HOLD)
//   busy       state is anything other than IDLE
//   timeout    one-cycle pulse during a CLEAR forced by the hold limit
//   dbg_state  current FSM state, for observation only
//
// Handshake: a station raises req[i] with a stable code and keeps both until
// gnt[i] pulses; the code is captured on the edge that enters LOAD, so the
// station drops req[i] the cycle after gnt[i]. A req still high at the next
// arbitration is treated as a fresh request. Downstream sees valid=1 in HOLD
// and answers with a single-cycle take; the code is then cleared.

module banda_sched #(
  parameter int HOLD_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] code,
  input  logic        take,
  output logic        reg_load,
  output logic        reg_clear,
  output logic        reg_a,
  output logic        reg_b,
  output logic        reg_c,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic        valid,
  output logic        busy,
  output logic        timeout,
  output logic [2:0]  dbg_state
);

  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_HOLD  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      owner_q;
  logic [1:0]      last_q;
  logic [2:0]      code_q;
  logic [CW-1:0]   hold_cnt_q;
  logic            to_q;

  logic            arb_en;
  logic            win_vld;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic [2:0]      win_code;
  logic            hold_expire;

  // Rotating-priority search starting at last+1; idx wraps naturally in 2 bits.
  always_comb begin
    win     = last_q;
    win_vld = 1'b0;
    idx     = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!win_vld && req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    win_code = code[2:0];
    case (win)
      2'd0: win_code = code[2:0];
      2'd1: win_code = code[5:3];
      2'd2: win_code = code[8:6];
      2'd3: win_code = code[11:9];
      default: win_code = code[2:0];
    endcase
  end

  // Arbitration is only allowed from the two "register is empty" states.
  assign arb_en      = win_vld && (state_q == S_IDLE || state_q == S_CLEAR);
  // take has priority over the limit, so expiry requires take low.
  assign hold_expire = (hold_cnt_q == HOLD_LAST) && !take;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_IDLE;
      S_IDLE:  state_d = win_vld ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_HOLD;
      S_HOLD:  state_d = (take || hold_expire) ? S_CLEAR : S_HOLD;
      S_CLEAR: state_d = win_vld ? S_LOAD : S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      owner_q    <= 2'd0;
      last_q     <= 2'd3;
      code_q     <= 3'd0;
      hold_cnt_q <= '0;
      to_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arb_en) begin
        owner_q <= win;
        last_q  <= win;
        code_q  <= win_code;
      end
      if (state_q == S_LOAD) begin
        hold_cnt_q <= '0;
      end else if (state_q == S_HOLD && !take) begin
        hold_cnt_q <= hold_cnt_q + CW'(1);
      end
      // Remembers that the coming CLEAR was forced, for the timeout pulse.
      to_q <= (state_q == S_HOLD) && hold_expire;
    end
  end

  // Moore decode. The state resets to INIT, so strobes are masked while
  // rst_n is low; the INIT clear then fires for the first cycle after release.
  always_comb begin
    reg_load  = 1'b0;
    reg_clear = 1'b0;
    gnt       = 4'b0000;
    valid     = 1'b0;
    timeout   = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_INIT:  reg_clear = 1'b1;
      S_LOAD:  begin
        reg_load = 1'b1;
        gnt      = 4'b0001 << owner_q;
      end
      S_HOLD:  valid = 1'b1;
      S_CLEAR: begin
        reg_clear = 1'b1;
        timeout   = to_q;
      end
      default: ;
    endcase
    if (!rst_n) begin
      reg_load  = 1'b0;
      reg_clear = 1'b0;
      gnt       = 4'b0000;
      valid     = 1'b0;
      timeout   = 1'b0;
      busy      = 1'b0;
    end
  end

  assign owner     = owner_q;
  assign reg_a     = code_q[2];
  assign reg_b     = code_q[1];
  assign reg_c     = code_q[0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_banda_sched.sv
module tb_banda_sched;

  localparam int HM = 4;

  localparam int PH_RST   = 0;
  localparam int PH_INIT  = 1;
  localparam int PH_IDLE  = 2;
  localparam int PH_LOAD  = 3;
  localparam int PH_HOLD  = 4;
  localparam int PH_CLEAR = 5;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] code;
  logic        take;
  logic        reg_load, reg_clear, reg_a, reg_b, reg_c;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        valid, busy, timeout;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  banda_sched #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .code(code), .take(take),
    .reg_load(reg_load), .reg_clear(reg_clear),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c),
    .gnt(gnt), .owner(owner), .valid(valid), .busy(busy),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  logic [13:0] obs;
  assign obs = {reg_load, reg_clear, gnt, owner, valid, busy, timeout,
                reg_a, reg_b, reg_c};

  // ---------------- reference model ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] stc[4];
  logic [1:0] m_owner;
  logic [2:0] m_abc;
  int         m_last;
  int         w, tk;
  logic       pend, have_req;

  // Output vector required for a given phase of the protocol.
  function automatic logic [13:0] expv(int ph, logic [1:0] own,
                                       logic [2:0] abc, logic to);
    logic       ld = 1'b0, cl = 1'b0, vl = 1'b0, bs = 1'b1, t = 1'b0;
    logic [3:0] g = 4'b0000;
    logic [1:0] o = own;
    logic [2:0] a = abc;
    case (ph)
      PH_RST:   begin bs = 1'b0; o = 2'd0; a = 3'd0; end
      PH_INIT:  cl = 1'b1;
      PH_IDLE:  bs = 1'b0;
      PH_LOAD:  begin ld = 1'b1; g = 4'b0001 << own; end
      PH_HOLD:  vl = 1'b1;
      PH_CLEAR: begin cl = 1'b1; t = to; end
      default:  ;
    endcase
    return {ld, cl, g, o, vl, bs, t, a};
  endfunction

  // Rotating priority: first requester at or after (last+1) mod 4.
  function automatic int pick(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_code();
    code = {stc[3], stc[2], stc[1], stc[0]};
  endtask

  task automatic grant_model(int s);
    m_owner = 2'(s);
    m_abc   = stc[s];
    m_last  = s;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic chk(string tag, int ph, logic to);
    logic [13:0] e;
    e = expv(ph, m_owner, m_abc, to);
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b (ld,cl,gnt,own,vld,busy,to,abc)",
             tag, obs, e);
    end
  endtask

  task automatic model_reset();
    m_owner = 2'd0;
    m_abc   = 3'd0;
    m_last  = 3;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; req = 4'b0; take = 1'b0; code = 12'd0;
    for (int s = 0; s < 4; s++) stc[s] = 3'd0;
    model_reset();
    repeat (2) step();
    chk("reset_outputs", PH_RST, 1'b0);

    rst_n = 1'b1;
    #2 chk("init_clear", PH_INIT, 1'b0);
    step(); chk("idle_after_init", PH_IDLE, 1'b0);
    step(); chk("idle_stays", PH_IDLE, 1'b0);

    // Single request from station 2, code 101.
    stc[2] = 3'b101; set_code(); req = 4'b0100;
    step(); grant_model(2); chk("dir_load", PH_LOAD, 1'b0);
    req = 4'b0;
    step(); chk("dir_hold", PH_HOLD, 1'b0);
    take = 1'b1;
    step(); take = 1'b0; chk("dir_clear", PH_CLEAR, 1'b0);
    step(); chk("dir_idle", PH_IDLE, 1'b0);

    // Reset pulsed during HOLD.
    stc[1] = 3'b011; set_code(); req = 4'b0010;
    step(); grant_model(1); chk("rst_pre_load", PH_LOAD, 1'b0);
    req = 4'b0;
    step(); chk("rst_pre_hold", PH_HOLD, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset(); chk("rst_async_drop", PH_RST, 1'b0);
    step(); rst_n = 1'b1;
    #2 chk("rst_init_clear", PH_INIT, 1'b0);
    step(); chk("rst_idle", PH_IDLE, 1'b0);

    // All four stations requesting continuously, take held high.
    for (int s = 0; s < 4; s++) stc[s] = 3'($urandom_range(0, 7));
    set_code(); req = 4'b1111; take = 1'b1;
    for (int g = 0; g < 5; g++) begin
      step(); grant_model(g % 4); chk("rr_load", PH_LOAD, 1'b0);
      if (g == 4) req = 4'b0;
      step(); chk("rr_hold", PH_HOLD, 1'b0);
      step(); chk("rr_clear", PH_CLEAR, 1'b0);
    end
    take = 1'b0;
    step(); chk("rr_idle", PH_IDLE, 1'b0);

    // No take: forced clear after HM HOLD cycles.
    req = 4'b1000;
    step(); grant_model(3); chk("to_load", PH_LOAD, 1'b0);
    req = 4'b0;
    for (int c = 1; c <= HM; c++) begin
      step(); chk("to_hold", PH_HOLD, 1'b0);
    end
    step(); chk("to_clear", PH_CLEAR, 1'b1);
    step(); chk("to_idle", PH_IDLE, 1'b0);

    // take on the last allowed HOLD cycle beats the timeout.
    req = 4'b0001;
    step(); grant_model(0); chk("tie_load", PH_LOAD, 1'b0);
    req = 4'b0;
    for (int c = 1; c <= HM; c++) begin
      step(); chk("tie_hold", PH_HOLD, 1'b0);
      if (c == HM) take = 1'b1;
    end
    step(); take = 1'b0; chk("tie_clear", PH_CLEAR, 1'b0);
    step(); chk("tie_idle", PH_IDLE, 1'b0);

    // take outside HOLD is ignored.
    take = 1'b1;
    step(); chk("take_idle", PH_IDLE, 1'b0);
    req = 4'b0010;
    step(); grant_model(1); chk("take_load", PH_LOAD, 1'b0);
    req = 4'b0;
    step(); take = 1'b0; chk("take_after_load", PH_HOLD, 1'b0);
    step(); chk("take_hold2", PH_HOLD, 1'b0);
    take = 1'b1;
    step(); take = 1'b0; chk("take_clear", PH_CLEAR, 1'b0);
    step(); chk("take_done_idle", PH_IDLE, 1'b0);

    // Station 1 withdraws before the CLEAR arbitration.
    req = 4'b0001;
    step(); grant_model(0); chk("wd_load", PH_LOAD, 1'b0);
    req = 4'b0;
    step(); chk("wd_hold", PH_HOLD, 1'b0);
    req = 4'b0010;
    step(); chk("wd_hold_req1", PH_HOLD, 1'b0);
    req = 4'b0; take = 1'b1;
    step(); take = 1'b0; chk("wd_clear", PH_CLEAR, 1'b0);
    step(); chk("wd_idle", PH_IDLE, 1'b0);
    step(); chk("wd_idle2", PH_IDLE, 1'b0);

    // Randomized transactions against the model.
    have_req = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (!have_req) begin
        for (int s = 0; s < 4; s++) stc[s] = 3'($urandom_range(0, 7));
        set_code(); req = 4'($urandom_range(1, 15));
      end
      step();
      w = pick(req, m_last);
      grant_model(w);
      chk("rnd_load", PH_LOAD, 1'b0);
      req  = 4'b0;
      tk   = $urandom_range(1, HM + 1);
      pend = (t == 29) ? 1'b0 : 1'($urandom_range(0, 1));
      step(); chk("rnd_hold", PH_HOLD, 1'b0);
      for (int c = 1; c <= HM; c++) begin
        if (c == tk) take = 1'b1;
        if ((c == tk || c == HM) && pend) begin
          for (int s = 0; s < 4; s++) stc[s] = 3'($urandom_range(0, 7));
          set_code(); req = 4'($urandom_range(1, 15));
        end
        step(); take = 1'b0;
        if (c == tk || c == HM) break;
        chk("rnd_hold", PH_HOLD, 1'b0);
      end
      chk("rnd_clear", PH_CLEAR, (tk > HM));
      have_req = pend;
      if (!pend) begin
        step(); chk("rnd_idle", PH_IDLE, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "time limit");
  end

endmodule
